// File: rtl/doppler_oif_pkg.sv
// Shared constants for the Doppler host output port.
// Mode encodings and connector pin indices.
package doppler_oif_pkg;
  localparam logic [1:0] IOUT_PAR = 2'b00;
  localparam logic [1:0] IOUT_SPI = 2'b01;

  localparam int PIN_STB  = 0;
  localparam int PIN_CSN  = 1;
  localparam int PIN_DRDY = 3;
  localparam int PIN_DLO  = 8;
endpackage

// File: rtl/oif_word_fifo.sv
// Single-clock show-ahead word FIFO.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module oif_word_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [AW:0]       cnt;
  logic              do_wr;
  logic              do_rd;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rp];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      if (do_wr & ~do_rd) cnt <= cnt + 1'b1;
      else if (do_rd & ~do_wr) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/doppler_output_port.sv
// Host readout port: word FIFO drained as bytes (parallel) or bits (SPI)
// over a shared 16-pin bidirectional connector.
module doppler_output_port
  import doppler_oif_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire  [15:0]       pins,
  input  logic [1:0]        iOut,
  input  logic              bufferNxt,
  input  logic [DATA_W-1:0] data,
  output logic              DataReady,
  output logic              finish
);
  localparam int NB = DATA_W / 8;
  localparam int PW = $clog2(DATA_W) + 1;

  logic              nxt_q;
  logic              stb_s1, stb_s2, stb_q;
  logic              csn_s1, csn_s2;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shifted;
  logic [PW-1:0]     pos;
  logic [PW-1:0]     last_pos;
  logic [PW+2:0]     shamt;
  logic              loaded;
  logic              push, pop, adv, last_adv;
  logic              act, par, mchg, stb_edge;
  logic [DATA_W-1:0] rd_data;
  logic              full, empty;
  logic              unused_pins;

  assign push     = bufferNxt & ~nxt_q;
  assign stb_edge = stb_s2 & ~stb_q;
  assign act      = ~csn_s2 & ~iOut[1];
  assign par      = (iOut == IOUT_PAR);
  assign mchg     = (iOut != mode_q);
  assign pop      = ~loaded & act & ~empty;
  assign adv      = loaded & act & stb_edge & ~mchg;
  assign last_pos = par ? PW'(NB - 1) : PW'(DATA_W - 1);
  assign last_adv = adv & (pos == last_pos);
  assign shamt    = par ? {pos, 3'b000} : {3'b000, pos};
  assign shifted  = shreg << shamt;

  assign DataReady   = loaded | ~empty;
  assign unused_pins = ^{pins[2], pins[7:4], full};

  oif_word_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  // CS_n sync idles high so the connector stays released out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      nxt_q  <= 1'b0;
      stb_s1 <= 1'b0;
      stb_s2 <= 1'b0;
      stb_q  <= 1'b0;
      csn_s1 <= 1'b1;
      csn_s2 <= 1'b1;
      mode_q <= IOUT_PAR;
      shreg  <= '0;
      pos    <= '0;
      loaded <= 1'b0;
      finish <= 1'b0;
    end else begin
      nxt_q  <= bufferNxt;
      stb_s1 <= pins[PIN_STB];
      stb_s2 <= stb_s1;
      stb_q  <= stb_s2;
      csn_s1 <= pins[PIN_CSN];
      csn_s2 <= csn_s1;
      mode_q <= iOut;
      finish <= last_adv & empty & ~push;
      if (pop) begin
        shreg  <= rd_data;
        loaded <= 1'b1;
        pos    <= '0;
      end else if (mchg) begin
        pos <= '0;
      end else if (adv) begin
        // last unit stays on the pins until the next word loads
        if (pos == last_pos) loaded <= 1'b0;
        else pos <= pos + 1'b1;
      end
    end
  end

  assign pins[PIN_DRDY] = act ? (par ? loaded : shifted[DATA_W-1]) : 1'bz;
  assign pins[PIN_DLO +: 8] = (act & par) ? shifted[DATA_W-1 -: 8] : 8'bz;
endmodule

// File: tb/tb_doppler_output_port.sv
// Directed bench for doppler_output_port.
// Released pins are pulled up, so high-impedance reads back as ones.
module tb_doppler_output_port;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  iOut = 2'b00;
  logic        bufferNxt = 1'b0;
  logic [63:0] data = '0;
  logic        stb = 1'b0;
  logic        csn = 1'b1;
  logic        DataReady;
  logic        finish;
  wire  [15:0] pins;

  int ncmp = 0;
  int nerr = 0;
  int fin_cnt = 0;
  int fin_base;
  logic [63:0] w;
  logic [63:0] words [4];
  logic [63:0] a5;

  assign pins[0] = stb;
  assign pins[1] = csn;
  assign pins[2] = 1'b0;

  for (genvar g = 3; g < 16; g++) begin : g_pu
    pullup (pins[g]);
  end

  doppler_output_port #(
    .DATA_W (64),
    .DEPTH  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pins      (pins),
    .iOut      (iOut),
    .bufferNxt (bufferNxt),
    .data      (data),
    .DataReady (DataReady),
    .finish    (finish)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (finish === 1'b1) fin_cnt++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] v);
    data = v;
    bufferNxt = 1'b1;
    tick(1);
    bufferNxt = 1'b0;
    tick(1);
  endtask

  task automatic strobe();
    stb = 1'b1;
    tick(3);
    stb = 1'b0;
    tick(3);
  endtask

  initial begin
    words[0] = 64'hFFFFFFFF00000000;
    words[1] = 64'h00000000FFFFFFFF;
    words[2] = 64'hFFFF00000000FFFF;
    words[3] = 64'hFFFFFFFF00000000;
    a5 = {8{8'hA5}};

    // reset
    tick(2);
    reset = 1'b0;
    tick(2);
    chk("rst_drdy", 64'(DataReady), 64'd0);
    chk("rst_finish", 64'(finish), 64'd0);
    chk("rst_pins_z", 64'(pins[15:3]), 64'h1FFF);

    // push four words with CS_n high
    data = words[0];
    bufferNxt = 1'b1;
    tick(1);
    bufferNxt = 1'b0;
    chk("push_drdy", 64'(DataReady), 64'd1);
    tick(1);
    for (int i = 1; i < 4; i++) push(words[i]);
    tick(3);
    chk("csn_hi_pins_z", 64'(pins[15:3]), 64'h1FFF);

    // parallel drain
    fin_base = fin_cnt;
    csn = 1'b0;
    tick(4);
    chk("par_drdy_pin", 64'(pins[3]), 64'd1);
    for (int k = 0; k < 32; k++) begin
      w = words[k/8];
      chk($sformatf("par_byte%0d", k), 64'(pins[15:8]),
          64'(w[63 - 8*(k%8) -: 8]));
      strobe();
    end
    chk("par_done_drdy", 64'(DataReady), 64'd0);
    chk("par_done_pin", 64'(pins[3]), 64'd0);
    chk("par_finish_cnt", 64'(fin_cnt - fin_base), 64'd1);

    // overflow: 17 pushes, 16 kept
    csn = 1'b1;
    tick(3);
    for (int i = 1; i <= 17; i++) push(64'(i));
    fin_base = fin_cnt;
    csn = 1'b0;
    tick(4);
    for (int j = 0; j < 16; j++) begin
      w = '0;
      for (int b = 0; b < 8; b++) begin
        w = {w[55:0], pins[15:8]};
        strobe();
      end
      chk($sformatf("ovf_word%0d", j), w, 64'(j + 1));
    end
    chk("ovf_drdy", 64'(DataReady), 64'd0);
    chk("ovf_finish_cnt", 64'(fin_cnt - fin_base), 64'd1);

    // SPI with a CS_n drop after 10 bits
    csn = 1'b1;
    tick(3);
    iOut = 2'b01;
    push(a5);
    fin_base = fin_cnt;
    csn = 1'b0;
    tick(4);
    chk("spi_data_z", 64'(pins[15:8]), 64'hFF);
    for (int i = 0; i < 64; i++) begin
      if (i == 10) begin
        csn = 1'b1;
        tick(4);
        chk("spi_hold_drdy", 64'(DataReady), 64'd1);
        csn = 1'b0;
        tick(4);
      end
      chk($sformatf("spi_bit%0d", i), 64'(pins[3]), 64'(a5[63-i]));
      strobe();
    end
    chk("spi_done_drdy", 64'(DataReady), 64'd0);
    chk("spi_finish_cnt", 64'(fin_cnt - fin_base), 64'd1);

    // disabled mode, then reset mid-word
    iOut = 2'b10;
    tick(3);
    push(64'h123456789ABCDEF0);
    chk("dis_drdy", 64'(DataReady), 64'd1);
    chk("dis_pins_z", 64'(pins[15:3]), 64'h1FFF);
    iOut = 2'b00;
    tick(3);
    chk("dis_load_b0", 64'(pins[15:8]), 64'h12);
    strobe();
    chk("dis_load_b1", 64'(pins[15:8]), 64'h34);
    fin_base = fin_cnt;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("mid_rst_drdy", 64'(DataReady), 64'd0);
    chk("mid_rst_pins_z", 64'(pins[15:3]), 64'h1FFF);
    tick(4);
    chk("mid_rst_drdy_pin", 64'(pins[3]), 64'd0);
    chk("mid_rst_no_finish", 64'(fin_cnt - fin_base), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
